// File: rtl/fp_window_accumulator.sv
// fp_window_accumulator
// Sums NUM_TERMS consecutive FP32 products into one window result using a
// sequential align/add/normalise datapath (4 cycles per term, truncating).
// Optional build macro RELU_EN: clamps negative window sums to +0 at output.
module fp_window_accumulator #(
  parameter int unsigned NUM_TERMS = 9,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] din,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    NORM  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  // Leading-zero count of a 24-bit mantissa; 24 when the value is zero.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      n = v[i] ? (5'd23 - 5'(i)) : n;
    end
    return n;
  endfunction

  // Right-shift used for alignment; shifts of 25 or more flush to zero.
  function automatic logic [23:0] align_shr(input logic [23:0] m, input logic [7:0] d);
    return (d >= 8'd25) ? 24'd0 : (m >> d);
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       term_q, term_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        exp_q, exp_d;
  logic [23:0]       ma_q, ma_d;
  logic [23:0]       mb_q, mb_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [24:0]       sum_q, sum_d;
  logic              sign_q, sign_d;
  logic [31:0]       dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic [7:0]        ea_s, eb_s;
  logic [23:0]       ma_s, mb_s;
  logic [4:0]        lzc_s;
  logic [23:0]       norm_mant_s;
  logic [9:0]        norm_exp_s;
  logic [31:0]       result_s;

  // Unpack accumulator and registered term; exponent field 0 means exact zero.
  always_comb begin
    ea_s = acc_q[30:23];
    eb_s = term_q[30:23];
    ma_s = (ea_s == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
    mb_s = (eb_s == 8'd0) ? 24'd0 : {1'b1, term_q[22:0]};
  end

  // Normalise the raw sum and pack it, applying zero/underflow/overflow rules.
  always_comb begin
    lzc_s = lzc24(sum_q[23:0]);
    if (sum_q[24]) begin
      norm_mant_s = sum_q[24:1];
      norm_exp_s  = {2'b00, exp_q} + 10'd1;
    end else begin
      norm_mant_s = sum_q[23:0] << lzc_s;
      norm_exp_s  = {2'b00, exp_q} - {5'd0, lzc_s};
    end
    if ((sum_q == 25'd0) || norm_exp_s[9] || (norm_exp_s == 10'd0)) begin
      result_s = 32'h0000_0000;
    end else if (norm_exp_s > 10'd254) begin
      result_s = {sign_q, 8'd254, 23'h7F_FFFF};
    end else begin
      result_s = {sign_q, norm_exp_s[7:0], norm_mant_s[22:0]};
    end
  end

  // Next-state and datapath control for the align/add/normalise sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    term_d  = term_q;
    count_d = count_q;
    exp_d   = exp_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    sign_d  = sign_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          term_d  = din;
          state_d = ALIGN;
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
        sa_d = acc_q[31];
        sb_d = term_q[31];
        if (ea_s >= eb_s) begin
          exp_d = ea_s;
          ma_d  = ma_s;
          mb_d  = align_shr(mb_s, ea_s - eb_s);
        end else begin
          exp_d = eb_s;
          ma_d  = align_shr(ma_s, eb_s - ea_s);
          mb_d  = mb_s;
        end
        state_d = ADD;
      end
      ADD: begin
        if (sa_q == sb_q) begin
          sum_d  = {1'b0, ma_q} + {1'b0, mb_q};
          sign_d = sa_q;
        end else if (ma_q > mb_q) begin
          sum_d  = {1'b0, ma_q - mb_q};
          sign_d = sa_q;
        end else if (mb_q > ma_q) begin
          sum_d  = {1'b0, mb_q - ma_q};
          sign_d = sb_q;
        end else begin
          sum_d  = 25'd0;
          sign_d = 1'b0;
        end
        state_d = NORM;
      end
      NORM: begin
        if (count_q == LAST_CNT) begin
`ifdef RELU_EN
          dout_d = result_s[31] ? 32'h0000_0000 : result_s;
`else
          dout_d = result_s;
`endif
          valid_d = 1'b1;
          acc_d   = 32'h0000_0000;
          count_d = '0;
        end else begin
          acc_d   = result_s;
          count_d = count_q + CNT_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 32'h0000_0000;
      term_q  <= 32'h0000_0000;
      count_q <= '0;
      exp_q   <= 8'd0;
      ma_q    <= 24'd0;
      mb_q    <= 24'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sum_q   <= 25'd0;
      sign_q  <= 1'b0;
      dout_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      term_q  <= term_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      sign_q  <= sign_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_fp_window_accumulator.sv
// Directed testbench for fp_window_accumulator with hand-computed sums.
module tb_fp_window_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] din;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] dout;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulses       = 0;

  always #5 clk = ~clk;

  fp_window_accumulator #(.NUM_TERMS(9), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .din       (din),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .dout      (dout)
  );

  // Count valid_out pulses away from the active edge.
  always @(negedge clk) begin
    if (valid_out === 1'b1) pulses <= pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Present one term and hold it until accepted; waits = cycles ready_out was low.
  task automatic send(input logic [31:0] d, output int waits);
    waits    = 0;
    valid_in = 1'b1;
    din      = d;
    while (ready_out !== 1'b1 && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 50) check_eq("ready_timeout", {31'd0, ready_out}, 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    din      = 32'h0;
  endtask

  // Called right after the last term is accepted: checks 3-cycle latency and result.
  task automatic finish_window(input string tag, input logic [31:0] exp, input int p0);
    check_eq({tag, "_v_e0"}, {31'd0, valid_out}, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      check_eq({tag, "_v_lat"}, {31'd0, valid_out}, 32'd0);
      check_eq({tag, "_rdy_lat"}, {31'd0, ready_out}, 32'd0);
    end
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check_eq({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    check_eq({tag, "_dout"}, dout, exp);
    @(negedge clk); #1;
    check_eq({tag, "_pulses"}, 32'(pulses), 32'(p0 + 1));
  endtask

  initial begin
    int w;
    int p0;
    logic [31:0] relu_exp;
    reset    = 1'b1;
    valid_in = 1'b0;
    din      = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, ready_out}, 32'd1);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_dout", dout, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Nine 1.0 terms -> 9.0, ready low exactly 3 cycles per term.
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      send(32'h3F80_0000, w);
      if (i > 0) check_eq("ones_ready_low", 32'(w), 32'd3);
    end
    finish_window("ones", 32'h4110_0000, p0);

    // 2.0 + 0.5 - 1.5 plus zeros (both signs) -> 1.0.
    p0 = pulses;
    send(32'h4000_0000, w);
    send(32'h3F00_0000, w);
    send(32'hBFC0_0000, w);
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0000, w);
    finish_window("mixed", 32'h3F80_0000, p0);

    // 1.0 - 1.0 -> +0 via cancellation.
    p0 = pulses;
    send(32'h3F80_0000, w);
    send(32'hBF80_0000, w);
    for (int i = 0; i < 7; i++) send(32'h0000_0000, w);
    finish_window("cancel", 32'h0000_0000, p0);

    // 2^24 + 1.0 truncates the aligned-out bit.
    p0 = pulses;
    send(32'h4B80_0000, w);
    send(32'h3F80_0000, w);
    for (int i = 0; i < 7; i++) send(32'h0000_0000, w);
    finish_window("trunc", 32'h4B80_0000, p0);

    // Reset mid-ALIGN after four terms discards the partial window.
    p0 = pulses;
    for (int i = 0; i < 4; i++) send(32'h3F80_0000, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midrst_ready", {31'd0, ready_out}, 32'd1);
    check_eq("midrst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("midrst_dout", dout, 32'h0);
    check_eq("midrst_pulses", 32'(pulses), 32'(p0));
    for (int i = 0; i < 9; i++) send(32'h3F80_0000, w);
    finish_window("after_rst", 32'h4110_0000, p0);

    // Back-to-back window of nine 2.0 -> 18.0; first accept needs no wait.
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      send(32'h4000_0000, w);
      if (i == 0) check_eq("b2b_no_gap", 32'(w), 32'd0);
    end
    finish_window("twos", 32'h4190_0000, p0);

    // Negative sum -3.0; clamped when the ReLU build is selected.
`ifdef RELU_EN
    relu_exp = 32'h0000_0000;
`else
    relu_exp = 32'hC040_0000;
`endif
    p0 = pulses;
    send(32'hC040_0000, w);
    for (int i = 0; i < 8; i++) send(32'h0000_0000, w);
    finish_window("neg", relu_exp, p0);

    @(posedge clk); #1;
    check_eq("final_valid_low", {31'd0, valid_out}, 32'd0);
    check_eq("final_dout_hold", dout, relu_exp);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
